// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard and issue controller between decode and execute.
// Tracks pending destination writes, stalls on RAW/WAW hazards or when the
// in-flight limit is reached, and clears tracking on writeback or flush.
module issue_scoreboard #(
  parameter int unsigned NREGS        = 32,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned WB_BYPASS    = 1,
  localparam int unsigned RegW        = $clog2(NREGS),
  localparam int unsigned CntW        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             dec_valid_i,
  input  logic [RegW-1:0]  dec_rs1_i,
  input  logic [RegW-1:0]  dec_rs2_i,
  input  logic [RegW-1:0]  dec_rd_i,
  output logic             dec_ready_o,
  input  logic             ex_ready_i,
  input  logic             wb_valid_i,
  input  logic [RegW-1:0]  wb_rd_i,
  input  logic             flush_i,
  output logic [NREGS-1:0] busy_mask_o,
  output logic [CntW-1:0]  inflight_o,
  output logic             wb_err_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CntW-1:0]  inflight_q, inflight_d;
  logic             wb_err_q, wb_err_d;

  logic [NREGS-1:0] wb_oh;
  logic [NREGS-1:0] eff;
  logic             wb_hit;
  logic             wb_dec;
  logic             raw, waw, full;
  logic             issue_wr;

  // Hazard detection and the zero-latency issue handshake.
  always_comb begin
    wb_oh = '0;
    wb_oh[wb_rd_i] = wb_valid_i;
    // With bypass, a register retiring this cycle no longer blocks issue.
    eff    = (WB_BYPASS != 0) ? (busy_q & ~wb_oh) : busy_q;
    wb_hit = busy_q[wb_rd_i];
    wb_dec = wb_valid_i & wb_hit & (wb_rd_i != '0);
    raw    = ((dec_rs1_i != '0) & eff[dec_rs1_i]) | ((dec_rs2_i != '0) & eff[dec_rs2_i]);
    waw    = (dec_rd_i != '0) & eff[dec_rd_i];
    // A same-cycle retirement frees a slot, so a full tracker may still accept.
    full   = (inflight_q == CntW'(MAX_INFLIGHT)) & (dec_rd_i != '0) & ~wb_dec;
    dec_ready_o = ex_ready_i & ~flush_i & ~raw & ~waw & ~full & ~rst_i;
    issue_wr    = dec_valid_i & dec_ready_o & (dec_rd_i != '0);
  end

  // Next-state: flush wipes tracking; otherwise retire then issue so a
  // same-register issue overrides the clear.
  always_comb begin
    busy_d     = busy_q;
    inflight_d = inflight_q;
    wb_err_d   = wb_err_q;
    if (flush_i) begin
      busy_d     = '0;
      inflight_d = '0;
    end else begin
      if (wb_dec) begin
        busy_d[wb_rd_i] = 1'b0;
      end
      if (issue_wr) begin
        busy_d[dec_rd_i] = 1'b1;
      end
      inflight_d = inflight_q + CntW'(issue_wr) - CntW'(wb_dec);
      if (wb_valid_i && (wb_rd_i != '0) && !wb_hit) begin
        wb_err_d = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      inflight_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign busy_mask_o = busy_q;
  assign inflight_o  = inflight_q;
  assign wb_err_o    = wb_err_q;

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Register-hazard scoreboard and issue controller between the decode stage and the execute/memory pipeline of the RV32I core.
- Tracks which architectural destination registers have an in-flight write, and stalls issue on RAW or WAW hazards or when the in-flight limit is reached.
- Clears tracking on writeback or pipeline flush.
- Decode supplies rs1/rs2/rd already zeroed for unused fields, so x0 never creates a hazard.

Parameters:
- NREGS, 32, number of architectural integer registers (x0 hardwired zero).
- MAX_INFLIGHT, 4, maximum outstanding register-writing instructions; range 1..15.
- WB_BYPASS, 1, when 1 a same-cycle writeback resolves a hazard for the instruction being issued.

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- dec_valid  input  1  decode holds a valid instruction.
- dec_rs1  input  5  source register 1 (0 = unused).
- dec_rs2  input  5  source register 2 (0 = unused).
- dec_rd  input  5  destination register (0 = no write).
- dec_ready  output  1  instruction is issued this cycle when dec_valid & dec_ready.
- ex_ready  input  1  execute stage can accept an instruction.
- wb_valid  input  1  a register write retires this cycle.
- wb_rd  input  5  register being written back.
- flush  input  1  kill all in-flight instructions (branch/jump redirect).
- busy_mask  output  NREGS  registered pending-write bit per register; bit 0 always 0.
- inflight  output  $clog2(MAX_INFLIGHT+1)  registered count of outstanding writers.
- wb_err  output  1  sticky: writeback arrived for a non-pending register.

Behaviour:
- Reset (async, immediate): busy_mask=0, inflight=0, wb_err=0. dec_ready reads 0 while rst=1.
- Effective pending set, eff = busy_mask & ~(WB_BYPASS & wb_valid ? onehot(wb_rd) : 0). When WB_BYPASS=0, eff = busy_mask.
- Hazard conditions (combinational):
  - raw = eff[rs1] (rs1≠0) | eff[rs2] (rs2≠0).
  - waw = eff[rd] (rd≠0).
  - full = (inflight == MAX_INFLIGHT) & (rd≠0) & ~wb_dec, where wb_dec = wb_valid & busy_mask[wb_rd] & wb_rd≠0.
- dec_ready = ex_ready & ~flush & ~raw & ~waw & ~full & ~rst. It is combinational, zero-latency, and may depend on dec_* only through the hazard terms.
- Issue event: dec_valid & dec_ready.
  - If rd≠0, set busy_mask[rd] next cycle and add 1 to inflight.
  - If rd=0, the instruction issues with no state change.
- Writeback event: wb_dec. Clear busy_mask[wb_rd] and subtract 1 from inflight.
- Writeback fault: wb_valid with wb_rd=0 is ignored silently. wb_valid with wb_rd≠0 and busy_mask[wb_rd]=0 sets wb_err (sticky until reset) and changes no other state.
- Simultaneous issue and writeback:
  - Net inflight change is (+1) + (−1) = 0.
  - If issue rd == wb_rd (possible only with WB_BYPASS=1), the set wins and the bit stays 1.
- Flush (synchronous, next edge): busy_mask=0, inflight=0. Issue is blocked in the flush cycle. A wb_valid in the flush cycle is discarded without raising wb_err. wb_err itself is not cleared.
- inflight never wraps. Overflow is impossible by construction via full; underflow is impossible because decrement requires busy_mask[wb_rd]=1.
- Invariant: inflight == popcount(busy_mask) at every edge. Verification asserts this.
- Reset asserted mid-operation clears all state regardless of pending writebacks. Post-reset writebacks to stale registers raise wb_err.
- Hold rule: dec_* may change while dec_ready=0. The block keeps no per-instruction state before issue.

Test Plan:
- Reset, then issue rd=5 (addi x5) with ex_ready=1: dec_ready=1; next cycle busy_mask=0x20, inflight=1.
- RAW stall: x5 pending, present rs1=5: dec_ready=0 until wb_valid, wb_rd=5. With WB_BYPASS=1, dec_ready=1 in the writeback cycle and busy_mask ends 0x00. With WB_BYPASS=0, issue occurs one cycle later.
- Full: issue rd=1,2,3,4 back-to-back with no writebacks (inflight=4); rd=6 stalls. rd=0 with sources x0 still issues. wb_rd=2 in the same cycle as rd=6 lets it issue, leaving inflight=4 and busy_mask=0x5A.
- WAW plus same-register writeback: x7 pending, issue rd=7 with wb_valid, wb_rd=7, WB_BYPASS=1: busy_mask[7] stays 1 and inflight stays 1.
- Flush: with busy_mask=0x1E and inflight=4, pulse flush together with dec_valid: dec_ready=0; next cycle busy_mask=0, inflight=0. A later wb_rd=3 sets wb_err=1, which stays 1 until rst.
- Async reset mid-stream: assert rst between clock edges with inflight=3: all outputs go to 0 immediately, without waiting for a clock edge; dec_ready=0 while rst=1.
